// File: rtl/mackerel_dram_pkg.sv
// Shared types and default timing constants for the
// DRAM refresh arbiter and its refresh tick timer.
package mackerel_dram_pkg;

    localparam int REFRESH_INTERVAL_DEF = 780;
    localparam int URGENT_LEVEL_DEF     = 4;
    localparam int PRECHARGE_CYCLES_DEF = 2;

    localparam int         REF_PEND_W   = 3;
    localparam logic [2:0] REF_PEND_MAX = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU_CYC,
        ST_REF_CYC,
        ST_RECOVER
    } arb_state_e;

    // Bits needed to hold n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_refresh_arbiter_if.sv
// Arbiter bus: CPU strobes and sequencer done in,
// grants, busy and refresh bookkeeping out.
interface dram_refresh_arbiter_if;
    import mackerel_dram_pkg::*;

    logic                  CS_n;
    logic                  AS_n;
    logic                  SEQ_DONE;
    logic                  GNT_CPU;
    logic                  GNT_REF;
    logic                  BUSY;
    logic [REF_PEND_W-1:0] REF_PENDING;
    logic                  REF_OVERRUN;

    modport master (
        output CS_n,
        output AS_n,
        output SEQ_DONE,
        input  GNT_CPU,
        input  GNT_REF,
        input  BUSY,
        input  REF_PENDING,
        input  REF_OVERRUN
    );

    modport slave (
        input  CS_n,
        input  AS_n,
        input  SEQ_DONE,
        output GNT_CPU,
        output GNT_REF,
        output BUSY,
        output REF_PENDING,
        output REF_OVERRUN
    );

endinterface

// File: rtl/dram_refresh_timer.sv
// Free-running down-counter; tick is high for one
// cycle every REFRESH_INTERVAL cycles.
module dram_refresh_timer
    import mackerel_dram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int W = cnt_width(REFRESH_INTERVAL);
    localparam logic [W-1:0] RELOAD = W'(REFRESH_INTERVAL - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == '0);

    // Reload on the tick cycle, otherwise count down.
    always_comb begin
        cnt_d = tick ? RELOAD : cnt_q - W'(1);
    end

    // Counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= RELOAD;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dram_refresh_arbiter.sv
// Arbitrates the DRAM between CPU cycles and CBR
// refreshes, with urgent-refresh priority.
module dram_refresh_arbiter
    import mackerel_dram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
    parameter int URGENT_LEVEL     = URGENT_LEVEL_DEF,
    parameter int PRECHARGE_CYCLES = PRECHARGE_CYCLES_DEF
) (
    input logic                  CLK,
    input logic                  RST,
    dram_refresh_arbiter_if.slave bus
);

    localparam int RW = cnt_width(PRECHARGE_CYCLES);
    localparam logic [RW-1:0] REC_LOAD = RW'(PRECHARGE_CYCLES - 1);

    logic                  tick;
    arb_state_e            state_q;
    logic                  gnt_cpu_q;
    logic                  gnt_ref_q;
    logic                  busy_q;
    logic [RW-1:0]         rec_q;
    logic                  served_q;
    logic                  served_d;
    logic [REF_PEND_W-1:0] pend_q;
    logic [REF_PEND_W-1:0] pend_d;
    logic                  ovr_q;
    logic                  ovr_d;
    logic                  cpu_req;
    logic                  urgent;
    logic                  in_idle;
    logic                  ref_grant;
    logic                  cpu_grant;

    dram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .tick (tick)
    );

    assign cpu_req   = !bus.CS_n && !bus.AS_n && !served_q;
    assign urgent    = int'(pend_q) >= URGENT_LEVEL;
    assign in_idle   = (state_q == ST_IDLE);
    assign ref_grant = in_idle &&
                       (urgent || (!cpu_req && pend_q != '0));
    assign cpu_grant = in_idle && !urgent && cpu_req;

    // Owed-refresh count: tick adds, grant removes,
    // a tick lost at saturation flags an overrun.
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (tick && !ref_grant) begin
            if (pend_q == REF_PEND_MAX) ovr_d = 1'b1;
            else pend_d = pend_q + 3'd1;
        end else if (!tick && ref_grant) begin
            pend_d = pend_q - 3'd1;
        end
    end

    // One grant per strobe: served until AS_n rises.
    always_comb begin
        served_d = bus.AS_n ? 1'b0 : (served_q | cpu_grant);
    end

    // Bookkeeping registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q   <= '0;
            ovr_q    <= 1'b0;
            served_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            served_q <= served_d;
        end
    end

    // Arbiter FSM with registered grant and busy outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            gnt_cpu_q <= 1'b0;
            gnt_ref_q <= 1'b0;
            busy_q    <= 1'b0;
            rec_q     <= '0;
        end else begin
            gnt_cpu_q <= 1'b0;
            gnt_ref_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (ref_grant) begin
                        state_q   <= ST_REF_CYC;
                        gnt_ref_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (cpu_grant) begin
                        state_q   <= ST_CPU_CYC;
                        gnt_cpu_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_CPU_CYC, ST_REF_CYC: begin
                    if (bus.SEQ_DONE) begin
                        state_q <= ST_RECOVER;
                        rec_q   <= REC_LOAD;
                    end
                end
                ST_RECOVER: begin
                    if (rec_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rec_q <= rec_q - RW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.GNT_CPU     = gnt_cpu_q;
    assign bus.GNT_REF     = gnt_ref_q;
    assign bus.BUSY        = busy_q;
    assign bus.REF_PENDING = pend_q;
    assign bus.REF_OVERRUN = ovr_q;

endmodule

// File: tb/tb_dram_refresh_arbiter.sv
// Lockstep bench for dram_refresh_arbiter against a
// cycle-level behavioural model of the arbitration rules.
module tb_dram_refresh_arbiter;

    localparam int RI = 16;
    localparam int UL = 4;
    localparam int PC = 2;

    localparam int P_IDLE = 0;
    localparam int P_CPU  = 1;
    localparam int P_REF  = 2;
    localparam int P_REC  = 3;

    logic CLK;
    logic RST;

    dram_refresh_arbiter_if bus ();

    dram_refresh_arbiter #(
        .REFRESH_INTERVAL(RI),
        .URGENT_LEVEL    (UL),
        .PRECHARGE_CYCLES(PC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    int m_phase, m_rec, m_pend, m_edges;
    bit m_ovr, m_served, m_gcpu, m_gref;

    // stimulus state
    bit drv_cs, drv_as;
    bit seq_en, noise_en, force_sd;
    int sd_left;
    int n_cpu, n_ref_obs, n_ref_exp, first_ref;

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_rec    = 0;
        m_pend   = 0;
        m_edges  = 0;
        m_ovr    = 0;
        m_served = 0;
        m_gcpu   = 0;
        m_gref   = 0;
        sd_left  = 0;
    endtask

    task automatic model_edge(input bit cs, input bit as_n,
                              input bit sd);
        bit tick;
        bit req;
        tick = (m_edges % RI) == RI - 1;
        m_edges++;
        req = !cs && !as_n && !m_served;
        m_gcpu = 0;
        m_gref = 0;
        case (m_phase)
            P_IDLE: begin
                if (m_pend >= UL)    m_gref = 1;
                else if (req)        m_gcpu = 1;
                else if (m_pend > 0) m_gref = 1;
                if (m_gref)      m_phase = P_REF;
                else if (m_gcpu) m_phase = P_CPU;
            end
            P_CPU, P_REF: begin
                if (sd) begin
                    m_phase = P_REC;
                    m_rec   = PC;
                end
            end
            default: begin
                m_rec--;
                if (m_rec == 0) m_phase = P_IDLE;
            end
        endcase
        m_pend = m_pend + int'(tick) - int'(m_gref);
        if (m_pend > 7) begin
            m_pend = 7;
            m_ovr  = 1;
        end
        if (as_n)        m_served = 0;
        else if (m_gcpu) m_served = 1;
    endtask

    task automatic step();
        bit sd;
        sd = 0;
        if (sd_left > 0) begin
            sd_left--;
            if (sd_left == 0 && seq_en) sd = 1;
        end
        if (force_sd) sd = 1;
        if (!sd && noise_en &&
            (m_phase == P_IDLE || m_phase == P_REC) &&
            $urandom_range(0, 5) == 0) sd = 1;
        bus.CS_n     = drv_cs;
        bus.AS_n     = drv_as;
        bus.SEQ_DONE = sd;
        @(posedge CLK);
        model_edge(drv_cs, drv_as, sd);
        #1;
        check("GNT_CPU", bus.GNT_CPU, 8'(m_gcpu));
        check("GNT_REF", bus.GNT_REF, 8'(m_gref));
        check("BUSY", bus.BUSY, 8'(m_phase != P_IDLE));
        check("REF_PENDING", bus.REF_PENDING, 8'(m_pend));
        check("REF_OVERRUN", bus.REF_OVERRUN, 8'(m_ovr));
        if (bus.GNT_CPU) n_cpu++;
        if (bus.GNT_REF) n_ref_obs++;
        if (m_gref) n_ref_exp++;
        if (bus.GNT_REF && first_ref < 0) first_ref = m_edges;
        if (m_gref || m_gcpu) sd_left = 4;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_GNT_CPU"}, bus.GNT_CPU, 8'd0);
        check({tag, "_GNT_REF"}, bus.GNT_REF, 8'd0);
        check({tag, "_BUSY"}, bus.BUSY, 8'd0);
        check({tag, "_PEND"}, bus.REF_PENDING, 8'd0);
        check({tag, "_OVR"}, bus.REF_OVERRUN, 8'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        check_zero("rst");
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        drv_cs = 1; drv_as = 1;
        seq_en = 1; noise_en = 0; force_sd = 0;
        bus.CS_n = 1'b1;
        bus.AS_n = 1'b1;
        bus.SEQ_DONE = 1'b0;
        first_ref = -1;
        model_reset();
        repeat (2) @(posedge CLK);
        do_reset();

        // idle bus: periodic refreshes only
        repeat (40) step();
        check("first_ref_edge", 8'(first_ref), 8'd17);
        check("idle_pend", bus.REF_PENDING, 8'd0);

        // strobe held low: one grant per strobe
        drv_cs = 0; drv_as = 0; n_cpu = 0;
        repeat (40) step();
        check("cpu_one_grant", 8'(n_cpu), 8'd1);
        drv_as = 1;
        step();
        drv_as = 0; n_cpu = 0;
        repeat (20) step();
        check("cpu_regrant", 8'(n_cpu), 8'd1);

        // back-to-back strobes let refreshes pile up
        noise_en = 1; n_ref_obs = 0; n_ref_exp = 0;
        drv_as = 1;
        step();
        repeat (200) begin
            drv_as = m_gcpu;
            step();
        end
        check("b2b_ref_count", 8'(n_ref_obs), 8'(n_ref_exp));

        // random strobes and chip selects
        repeat (300) begin
            drv_cs = ($urandom_range(0, 3) == 0);
            drv_as = ($urandom_range(0, 2) == 0);
            step();
        end

        // sequencer stall: saturation and overrun
        drv_cs = 1; drv_as = 1; seq_en = 0;
        repeat (10 * RI) step();
        check("stall_pend", bus.REF_PENDING, 8'd7);
        check("stall_ovr", bus.REF_OVERRUN, 8'd1);
        seq_en = 1;
        if (m_phase == P_CPU || m_phase == P_REF) sd_left = 1;
        repeat (60) step();
        check("ovr_sticky", bus.REF_OVERRUN, 8'd1);

        // tick coincident with a refresh grant at 2 owed
        seq_en = 0; noise_en = 0;
        do_reset();
        while (m_edges < 60) step();
        force_sd = 1;
        step();
        force_sd = 0;
        while (m_edges < 63) step();
        step();
        check("coinc_gnt_ref", bus.GNT_REF, 8'd1);
        check("coinc_pend", bus.REF_PENDING, 8'd2);

        // asynchronous reset in the middle of a refresh
        #2;
        RST = 1'b1;
        #1;
        check_zero("midrst");
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        seq_en = 1; noise_en = 1;
        step();
        check("post_rst_gnt_ref", bus.GNT_REF, 8'd0);
        repeat (30) step();

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
